// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions (poly 0x07, init 0x00, MSB-first, no reflection).
// Used by both the serial generator and the serial checker.
package crc8_pkg;

    localparam int              CRC_W     = 8;
    localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;
    localparam logic [CRC_W-1:0] CRC8_INIT = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } crc8_state_e;

    // One direct-form LFSR update for a single serial bit.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] lfsr,
                                                   input logic             din_bit);
        logic fb;
        fb = din_bit ^ lfsr[CRC_W-1];
        return {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : CRC8_INIT);
    endfunction

endpackage

// File: rtl/crc8_lfsr_step.sv
// Combinational single-bit CRC-8 LFSR update.
module crc8_lfsr_step
    import crc8_pkg::*;
(
    input  logic [CRC_W-1:0] lfsr_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] lfsr_o
);

    // Pure next-state function; no storage here.
    always_comb begin
        lfsr_o = crc8_step(lfsr_i, bit_i);
    end

endmodule

// File: rtl/crc8_serial_check.sv
// Serial CRC-8 frame checker: deserialises DATA_BITS payload bits plus 8 CRC
// bits (MSB first), divides the whole frame by x^8+x^2+x+1 and reports the
// syndrome. Gaps in din_vld shorter than GAP_MAX are transparent; a gap of
// GAP_MAX cycles aborts the frame with a one-cycle timeout pulse.
//
// state | meaning
// IDLE  | waiting for the first bit of a frame
// DATA  | accepting payload bits
// CRC   | accepting CRC bits
// DONE  | frame_vld cycle; a valid bit here starts the next frame
module crc8_serial_check
    import crc8_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int GAP_MAX   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 din_vld,
    input  logic                 clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic [CRC_W-1:0]     crc_rx,
    output logic [CRC_W-1:0]     syndrome,
    output logic                 frame_vld,
    output logic                 crc_ok,
    output logic                 crc_err,
    output logic                 timeout
);

    localparam int BCW = $clog2(DATA_BITS + 8 + 1);
    localparam int GCW = $clog2(GAP_MAX + 1);

    crc8_state_e          state_q;
    logic [CRC_W-1:0]     lfsr_q, lfsr_base, lfsr_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CRC_W-1:0]     crc_sh_q, crc_sh_d;
    logic [BCW-1:0]       bit_cnt_q;
    logic [GCW-1:0]       gap_cnt_q;
    logic [DATA_BITS-1:0] data_out_q;
    logic [CRC_W-1:0]     crc_rx_q, syndrome_q;
    logic                 frame_vld_q, crc_ok_q, crc_err_q, timeout_q;

    // The first bit of a frame (from IDLE or DONE) divides from a fresh LFSR.
    always_comb begin
        lfsr_base = ((state_q == IDLE) || (state_q == DONE)) ? CRC8_INIT : lfsr_q;
        shreg_d   = (shreg_q << 1) | DATA_BITS'(din);
        crc_sh_d  = (crc_sh_q << 1) | CRC_W'(din);
    end

    crc8_lfsr_step u_step (
        .lfsr_i (lfsr_base),
        .bit_i  (din),
        .lfsr_o (lfsr_d)
    );

    // Frame sequencing, gap watchdog and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= CRC8_INIT;
            shreg_q     <= '0;
            crc_sh_q    <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            data_out_q  <= '0;
            crc_rx_q    <= '0;
            syndrome_q  <= '0;
            frame_vld_q <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            frame_vld_q <= 1'b0;
            timeout_q   <= 1'b0;
            if (clr) begin
                state_q    <= IDLE;
                lfsr_q     <= CRC8_INIT;
                shreg_q    <= '0;
                crc_sh_q   <= '0;
                bit_cnt_q  <= '0;
                gap_cnt_q  <= '0;
                data_out_q <= '0;
                crc_rx_q   <= '0;
                syndrome_q <= '0;
                crc_ok_q   <= 1'b0;
                crc_err_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        gap_cnt_q <= '0;
                        if (din_vld) begin
                            lfsr_q    <= lfsr_d;
                            shreg_q   <= shreg_d;
                            bit_cnt_q <= BCW'(1);
                            state_q   <= (DATA_BITS == 1) ? CRC : DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    DATA, CRC: begin
                        if (din_vld) begin
                            gap_cnt_q <= '0;
                            lfsr_q    <= lfsr_d;
                            if (state_q == DATA) begin
                                shreg_q   <= shreg_d;
                                bit_cnt_q <= bit_cnt_q + BCW'(1);
                                if (bit_cnt_q == BCW'(DATA_BITS - 1))
                                    state_q <= CRC;
                            end else begin
                                crc_sh_q <= crc_sh_d;
                                if (bit_cnt_q == BCW'(DATA_BITS + 7)) begin
                                    state_q     <= DONE;
                                    bit_cnt_q   <= '0;
                                    data_out_q  <= shreg_q;
                                    crc_rx_q    <= crc_sh_d;
                                    syndrome_q  <= lfsr_d;
                                    crc_ok_q    <= (lfsr_d == CRC8_INIT);
                                    crc_err_q   <= (lfsr_d != CRC8_INIT);
                                    frame_vld_q <= 1'b1;
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + BCW'(1);
                                end
                            end
                        end else if (gap_cnt_q == GCW'(GAP_MAX - 1)) begin
                            // Partial frame is dropped; result outputs keep the last frame.
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                            gap_cnt_q <= '0;
                            bit_cnt_q <= '0;
                            lfsr_q    <= CRC8_INIT;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GCW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_out  = data_out_q;
    assign crc_rx    = crc_rx_q;
    assign syndrome  = syndrome_q;
    assign frame_vld = frame_vld_q;
    assign crc_ok    = crc_ok_q;
    assign crc_err   = crc_err_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_crc8_serial_check.sv
// Scoreboard bench for crc8_serial_check: the driver pushes expected events,
// a negedge monitor pops and compares whenever frame_vld or timeout fires.
module tb_crc8_serial_check;

    localparam int DB = 8;
    localparam int GM = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          din_vld = 1'b0;
    logic          clr = 1'b0;
    logic [DB-1:0] data_out;
    logic [7:0]    crc_rx, syndrome;
    logic          frame_vld, crc_ok, crc_err, timeout;

    crc8_serial_check #(.DATA_BITS(DB), .GAP_MAX(GM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .clr       (clr),
        .data_out  (data_out),
        .crc_rx    (crc_rx),
        .syndrome  (syndrome),
        .frame_vld (frame_vld),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_to;
        logic [DB-1:0] data;
        logic [7:0]    crc;
        logic [7:0]    syn;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Outputs the model expects the DUT to be holding right now.
    logic [DB-1:0] last_data = '0;
    logic [7:0]    last_crc  = '0;
    logic [7:0]    last_syn  = '0;

    // Remainder of a bit-string polynomial modulo x^8+x^2+x+1 by long division.
    function automatic logic [7:0] poly_mod(input logic [DB+15:0] v);
        logic [DB+15:0] r;
        logic [DB+15:0] g;
        r = v;
        g = {{(DB+7){1'b0}}, 9'h107};
        for (int i = DB + 15; i >= 8; i--)
            if (r[i]) r = r ^ (g << (i - 8));
        return r[7:0];
    endfunction

    function automatic logic [7:0] good_crc(input logic [DB-1:0] d);
        return poly_mod({8'h00, d, 8'h00});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input logic v, input logic b);
        din_vld = v;
        din     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic [7:0] c, input int maxgap);
        logic [DB+7:0] fr;
        exp_t e;
        int g;
        fr = {d, c};
        for (int i = DB + 7; i >= 0; i--) begin
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (g) tick(1'b0, 1'b0);
            if (i == 0) begin
                e.is_to = 1'b0;
                e.data  = d;
                e.crc   = c;
                e.syn   = poly_mod({d, c, 8'h00});
                e.cyc   = cyc + 1;
                q.push_back(e);
                last_data = d;
                last_crc  = c;
                last_syn  = e.syn;
            end
            tick(1'b1, fr[i]);
        end
        din_vld = 1'b0;
    endtask

    task automatic send_bits(input logic [DB-1:0] d, input logic [7:0] c, input int n);
        logic [DB+7:0] fr;
        fr = {d, c};
        for (int i = 0; i < n; i++) tick(1'b1, fr[DB+7-i]);
        din_vld = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_crc_rx"}, crc_rx, 0);
        chk({tag, "_syndrome"}, syndrome, 0);
        chk({tag, "_crc_ok"}, crc_ok, 0);
        chk({tag, "_crc_err"}, crc_err, 0);
        chk({tag, "_pulses"}, {frame_vld, timeout}, 0);
    endtask

    // Monitor: every output event must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (frame_vld || timeout)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {frame_vld, timeout}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_is_timeout", timeout, e.is_to);
                chk("event_frame_vld", frame_vld, !e.is_to);
                chk("event_cycle", cyc, e.cyc);
                chk("data_out", data_out, e.data);
                chk("crc_rx", crc_rx, e.crc);
                chk("syndrome", syndrome, e.syn);
                chk("crc_ok", crc_ok, e.syn == 8'h00);
                chk("crc_err", crc_err, e.syn != 8'h00);
            end
        end
    end

    initial begin
        exp_t e;
        logic [DB-1:0] d;
        logic [7:0]    c;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        send_frame(8'hFF, 8'hF3, 0);
        tick(1'b0, 1'b0);
        send_frame(8'hFF, 8'hF2, 0);
        tick(1'b0, 1'b0);
        send_frame(8'h80, 8'h89, 0);
        tick(1'b0, 1'b0);
        send_frame(8'h01, 8'h07, GM - 1);
        repeat (3) tick(1'b0, 1'b0);

        // Back-to-back: good, corrupted, good.
        send_frame(8'h3C, good_crc(8'h3C), 0);
        send_frame(8'hA5, good_crc(8'hA5) ^ 8'h10, 0);
        send_frame(8'h5A, good_crc(8'h5A), 0);
        repeat (3) tick(1'b0, 1'b0);

        // Gap of GM cycles after 5 bits aborts; outputs keep the previous frame.
        send_bits(8'hC3, good_crc(8'hC3), 5);
        e.is_to = 1'b1;
        e.data  = last_data;
        e.crc   = last_crc;
        e.syn   = last_syn;
        e.cyc   = cyc + GM;
        q.push_back(e);
        repeat (GM + 3) tick(1'b0, 1'b0);
        send_frame(8'h96, good_crc(8'h96), 0);
        repeat (2) tick(1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            d = DB'($urandom);
            c = good_crc(d);
            if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_frame(d, c, ($urandom_range(0, 1) == 1) ? GM - 1 : 0);
            if ($urandom_range(0, 1) == 1) tick(1'b0, 1'b0);
        end
        repeat (2) tick(1'b0, 1'b0);

        // clr at bit 10: bit dropped, everything zeroed.
        send_bits(8'h77, good_crc(8'h77), 10);
        clr = 1'b1;
        tick(1'b1, 1'b1);
        clr = 1'b0;
        din_vld = 1'b0;
        chk_zero("clr");
        last_data = '0;
        last_crc  = '0;
        last_syn  = '0;
        tick(1'b0, 1'b0);
        send_frame(8'hFF, 8'hF3, 0);
        repeat (2) tick(1'b0, 1'b0);

        // Asynchronous reset mid-CRC.
        send_bits(8'h42, good_crc(8'h42), 12);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk_zero("rst_hold");
        rst_n = 1'b1;
        last_data = '0;
        last_crc  = '0;
        last_syn  = '0;
        tick(1'b0, 1'b0);
        send_frame(8'hFF, 8'hF3, 0);

        repeat (5) tick(1'b0, 1'b0);
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
